aes128_iter_ctrl: RTL and testbench

Iterative AES-128 encryption controller. Accepts one plaintext/key pair over a valid/ready handshake. Sequences the initial AddRoundKey, rounds 1–9 (SubBytes, ShiftRows, MixColumns, AddRoundKey) and the final round without MixColumns through the team's sub_byte, shift_rows and mix_columns datapath blocks. Expands round keys on the fly. Delivers ciphertext over a second valid/ready handshake. Sits between the host-side block buffer and the cipher datapath.

---
 rtl/aes128_iter_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_aes128_iter_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption controller: one round per cycle with on-the-fly key expansion.
// Optional abort input is enabled with `define AES_CTRL_ABORT_EN.

// Single-byte AES S-box lookup.
module sub_byte (
    input  logic [7:0] x,
    output logic [7:0] s
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign s = SBOX[x];
endmodule

// Row r of the column-major state rotates left by r columns.
module shift_rows (
    input  logic [127:0] st,
    output logic [127:0] sr
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[127-8*(r+4*c) -: 8] = st[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end
endmodule

// One state column times the fixed MixColumns matrix over GF(2^8).
module mix_column (
    input  logic [31:0] col,
    output logic [31:0] mix
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = col;

    assign mix[31:24] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mix[23:16] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mix[15:8]  = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mix[7:0]   = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
endmodule

module mix_columns (
    input  logic [127:0] st,
    output logic [127:0] mc
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_column u_col (
            .col (st[127-32*c -: 32]),
            .mix (mc[127-32*c -: 32])
        );
    end
endmodule

module aes128_iter_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_idx
`ifdef AES_CTRL_ABORT_EN
    ,
    input  logic         abort
`endif
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t         fsm, fsm_nx;
    logic [127:0] state_reg, state_nx;
    logic [127:0] key_reg, key_nx;
    logic [7:0]   rcon, rcon_nx;
    logic [3:0]   rnd_nx;
    logic         abort_hit;

`ifdef AES_CTRL_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Round-key expansion: SubWord(RotWord(w3)) needs four S-box lookups.
    logic [31:0]  w0, w1, w2, w3, rot, sub_w;
    logic [31:0]  k0, k1, k2, k3;
    logic [127:0] key_next;

    assign {w0, w1, w2, w3} = key_reg;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_ksub
        sub_byte u_sb (.x(rot[31-8*i -: 8]), .s(sub_w[31-8*i -: 8]));
    end

    assign k0 = w0 ^ sub_w ^ {rcon, 24'h0};
    assign k1 = w1 ^ k0;
    assign k2 = w2 ^ k1;
    assign k3 = w3 ^ k2;
    assign key_next = {k0, k1, k2, k3};

    // Round datapath: SubBytes -> ShiftRows -> (MixColumns) -> AddRoundKey.
    logic [127:0] sb_out, sr_out, mc_out, round_out;

    for (genvar i = 0; i < 16; i++) begin : g_ssub
        sub_byte u_sb (.x(state_reg[127-8*i -: 8]), .s(sb_out[127-8*i -: 8]));
    end

    shift_rows  u_sr (.st(sb_out), .sr(sr_out));
    mix_columns u_mc (.st(sr_out), .mc(mc_out));

    assign round_out = ((round_idx == 4'd10) ? sr_out : mc_out) ^ key_next;

    always_comb begin
        fsm_nx   = fsm;
        state_nx = state_reg;
        key_nx   = key_reg;
        rcon_nx  = rcon;
        rnd_nx   = round_idx;
        case (fsm)
            IDLE: begin
                if (in_valid) begin
                    state_nx = in_data ^ in_key;
                    key_nx   = in_key;
                    rcon_nx  = 8'h01;
                    rnd_nx   = 4'd1;
                    fsm_nx   = ROUND;
                end
            end
            ROUND: begin
                if (abort_hit) begin
                    fsm_nx = IDLE;
                    rnd_nx = 4'd0;
                end else begin
                    state_nx = round_out;
                    key_nx   = key_next;
                    rcon_nx  = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    if (round_idx == 4'd10) begin
                        fsm_nx = DONE;
                        rnd_nx = 4'd0;
                    end else begin
                        rnd_nx = round_idx + 4'd1;
                    end
                end
            end
            DONE: begin
                if (out_ready || abort_hit) fsm_nx = IDLE;
            end
            default: fsm_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rcon      <= 8'h01;
            round_idx <= 4'd0;
        end else begin
            fsm       <= fsm_nx;
            state_reg <= state_nx;
            key_reg   <= key_nx;
            rcon      <= rcon_nx;
            round_idx <= rnd_nx;
        end
    end

    // Gated by rst so the pair is never offered as accepted while reset is held.
    assign in_ready  = (fsm == IDLE) && !rst;
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm == ROUND);
    assign out_data  = state_reg;
endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Directed bench for aes128_iter_ctrl using FIPS-197 known-answer vectors.
module tb_aes128_iter_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   round_idx;
`ifdef AES_CTRL_ABORT_EN
    logic         abort;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_iter_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_idx (round_idx)
`ifdef AES_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Assumes the controller is idle; out_ready is held high throughout.
    task automatic encrypt(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp);
        int lat, bcnt;
        chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        in_data = pt; in_key = k; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data = '1; in_key = '1;
        lat = 0; bcnt = 0;
        while (!out_valid && lat < 30) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd10);
        chk({tag, "_busy_cycles"}, 128'(bcnt), 128'd10);
        chk({tag, "_ct"}, out_data, exp);
        step();
        chk({tag, "_done_1cyc"}, 128'(out_valid), 128'd0);
        chk({tag, "_idle_ready"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        int n, a1, a2, got, cyc;
        logic ok;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b1;
`ifdef AES_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        step(); step();
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_round", 128'(round_idx), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 128'(in_ready), 128'd1);

        encrypt("fips_b", PT1, K1, CT1);
        encrypt("fips_c1", PT2, K2, CT2);

        // Backpressure with all-zero vector.
        out_ready = 1'b0;
        in_data = '0; in_key = '0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        chk("bp_latency", 128'(n), 128'd10);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!(out_valid === 1'b1 && out_data === CT0 && in_ready === 1'b0)) ok = 1'b0;
            step();
        end
        chk("bp_hold_stable", 128'(ok), 128'd1);
        chk("bp_ct", out_data, CT0);
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 128'(out_valid), 128'd0);
        chk("bp_release_ready", 128'(in_ready), 128'd1);

        // in_valid held high: back-to-back blocks 12 cycles apart.
        in_data = PT1; in_key = K1; in_valid = 1'b1;
        a1 = -1; a2 = -1; got = 0; cyc = 0;
        while (got < 2 && cyc < 60) begin
            step();
            cyc++;
            if (busy && round_idx == 4'd1) begin
                if (a1 < 0) begin
                    a1 = cyc;
                    in_data = PT2; in_key = K2;
                end else begin
                    a2 = cyc;
                    in_valid = 1'b0;
                    in_data = '1; in_key = '0;
                end
            end
            if (cyc == a1 + 5) begin in_data = ~PT2; in_key = ~K2; end
            if (cyc == a1 + 7) begin in_data = PT2; in_key = K2; end
            if (out_valid) begin
                chk(got == 0 ? "b2b_ct_a" : "b2b_ct_b", out_data, got == 0 ? CT1 : CT2);
                got++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_outputs", 128'(got), 128'd2);
        chk("b2b_spacing", 128'(a2 - a1), 128'd12);
        step();

        // Reset mid-ROUND.
        in_data = PT2; in_key = K2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd5 && n < 20) begin step(); n++; end
        chk("midrst_reach5", 128'(round_idx), 128'd5);
        rst = 1'b1;
        step();
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_valid", 128'(out_valid), 128'd0);
        chk("midrst_round", 128'(round_idx), 128'd0);
        chk("midrst_data", out_data, 128'd0);
        rst = 1'b0;
        #1;
        encrypt("after_rst", PT1, K1, CT1);

`ifdef AES_CTRL_ABORT_EN
        in_data = PT1; in_key = K1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd3 && n < 20) begin step(); n++; end
        chk("abort_reach3", 128'(round_idx), 128'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_round", 128'(round_idx), 128'd0);
        chk("abort_ready", 128'(in_ready), 128'd1);
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) ok = 1'b0;
            step();
        end
        chk("abort_no_output", 128'(ok), 128'd1);
        encrypt("after_abort", PT2, K2, CT2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
